// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus types and constants for master, arbiter and slave ports
package bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEL,
        ST_CONN,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_SUSP,
        ST_DONE
    } bus_state_t;

    localparam int         SEL_CYCLES    = 3;
    localparam logic [1:0] SLAVE_ILLEGAL = 2'd3;

endpackage

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - parallel-load shift register, MSB first, serial in at LSB
module bus_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         serial_in,
    output logic [W-1:0] q
);

    // q[W-1] is the serial output bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[W-2:0], serial_in};
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - master-side serial bus controller with split suspension and timeout
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_slave,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              m_request,
    output logic              m_address_valid,
    output logic              m_address,
    output logic              m_data,
    output logic              m_valid,
    output logic              m_write_en,
    input  logic              m_available,
    input  logic              m_ready,
    input  logic              m_data_in,
    input  logic              m_valid_in
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    bus_state_t        state, state_next, ret_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              write_q;
    logic [1:0]        slave_q;
    logic              err_q;
    logic              accept, bit_step, err_set, rdata_done, timed_out, counting, state_change;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              unused_bits;

    assign accept       = cmd_valid && (state == ST_IDLE);
    assign timed_out    = (to_cnt == TO_W'(TIMEOUT));
    assign counting     = state inside {ST_REQ, ST_CONN, ST_RDATA, ST_SUSP};
    assign state_change = (state_next != state);
    // Only the MSB of the outgoing registers leaves the block
    assign unused_bits  = ^{addr_q[ADDR_W-2:0], wdata_q[DATA_W-2:0], rdata_q[DATA_W-1]};

    bus_shift_reg #(.W(ADDR_W)) u_addr_sr (
        .clk(clk), .reset(reset), .load(accept), .load_data(cmd_addr),
        .shift_en(bit_step && (state == ST_ADDR)), .serial_in(1'b0), .q(addr_q)
    );

    bus_shift_reg #(.W(DATA_W)) u_wdata_sr (
        .clk(clk), .reset(reset), .load(accept), .load_data(cmd_wdata),
        .shift_en(bit_step && (state == ST_WDATA)), .serial_in(1'b0), .q(wdata_q)
    );

    bus_shift_reg #(.W(DATA_W)) u_rdata_sr (
        .clk(clk), .reset(reset), .load(accept), .load_data('0),
        .shift_en(bit_step && (state == ST_RDATA)), .serial_in(m_data_in), .q(rdata_q)
    );

    always_comb begin
        state_next      = state;
        bit_step        = 1'b0;
        err_set         = 1'b0;
        rdata_done      = 1'b0;
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_error       = 1'b0;
        m_request       = 1'b0;
        m_address_valid = 1'b0;
        m_address       = 1'b0;
        m_data          = 1'b0;
        m_valid         = 1'b0;
        m_write_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                err_set   = (cmd_slave == SLAVE_ILLEGAL);
                if (cmd_valid) state_next = err_set ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                m_request       = 1'b1;
                m_address_valid = 1'b1;
                if (m_available) begin
                    state_next = ST_SEL;
                end else if (timed_out) begin
                    state_next = ST_DONE;
                    err_set    = 1'b1;
                end
            end
            ST_SEL: begin
                m_request = 1'b1;
                m_valid   = 1'b1;
                bit_step  = 1'b1;
                m_address = (bit_cnt == CNT_W'(SEL_CYCLES - 1)) ? slave_q[0] : slave_q[1];
                if (bit_cnt == CNT_W'(SEL_CYCLES - 1)) state_next = ST_CONN;
            end
            ST_CONN: begin
                m_request = 1'b1;
                if (m_ready) begin
                    state_next = ST_ADDR;
                end else if (timed_out) begin
                    state_next = ST_DONE;
                    err_set    = 1'b1;
                end
            end
            ST_ADDR: begin
                m_request  = 1'b1;
                m_valid    = 1'b1;
                m_address  = addr_q[ADDR_W-1];
                m_write_en = write_q;
                // A bit counts as delivered only if the bus is still ours and the slave is ready
                if (!(m_available && m_ready)) begin
                    state_next = ST_SUSP;
                end else begin
                    bit_step = 1'b1;
                    if (bit_cnt == CNT_W'(ADDR_W - 1)) state_next = write_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                m_request  = 1'b1;
                m_valid    = 1'b1;
                m_data     = wdata_q[DATA_W-1];
                m_write_en = write_q;
                if (!(m_available && m_ready)) begin
                    state_next = ST_SUSP;
                end else begin
                    bit_step = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) state_next = ST_DONE;
                end
            end
            ST_RDATA: begin
                m_request = 1'b1;
                if (m_valid_in) begin
                    bit_step = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state_next = ST_DONE;
                        rdata_done = 1'b1;
                    end
                end else if (timed_out) begin
                    state_next = ST_DONE;
                    err_set    = 1'b1;
                end
            end
            ST_SUSP: begin
                m_request = 1'b1;
                if (m_available && m_ready) begin
                    state_next = ret_state;
                end else if (timed_out) begin
                    state_next = ST_DONE;
                    err_set    = 1'b1;
                end
            end
            ST_DONE: begin
                rsp_valid  = 1'b1;
                rsp_error  = err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            write_q   <= 1'b0;
            slave_q   <= '0;
            err_q     <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q <= cmd_write;
                slave_q <= cmd_slave;
            end
            if (state_next == ST_SUSP && state != ST_SUSP) ret_state <= state;
            if (state_next == ST_DONE && state != ST_DONE) err_q <= err_set;
            if (rdata_done) rsp_rdata <= {rdata_q[DATA_W-2:0], m_data_in};
            // Suspension keeps the bit position so the unacknowledged bit is resent
            if (state_change && state != ST_SUSP && state_next != ST_SUSP) begin
                bit_cnt <= '0;
            end else if (bit_step) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (state_change || bit_step) begin
                to_cnt <= '0;
            end else if (counting) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - directed vector bench for bus_master_port
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_slave;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [7:0]  rsp_rdata;
    logic        m_request, m_address_valid, m_address, m_data, m_valid, m_write_en;
    logic        m_available, m_ready, m_data_in, m_valid_in;

    bus_master_port #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .m_request(m_request), .m_address_valid(m_address_valid), .m_address(m_address),
        .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en),
        .m_available(m_available), .m_ready(m_ready),
        .m_data_in(m_data_in), .m_valid_in(m_valid_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit [1:0]    sl;
        bit [11:0]   ad;
        bit [7:0]    wd;
        bit [7:0]    rd;
        logic [22:0] ea;
        logic [22:0] ed;
        int          en;
        bit          ee;
        logic [7:0]  er;
    } vec_t;

    vec_t vt[5];

    int total = 0;
    int bad   = 0;

    logic [22:0] r_abits, r_dbits;
    logic [7:0]  r_rdata;
    int          r_nack, r_rsp_cyc, r_last_ack, r_wen_bad, r_stall_bad;
    bit          r_got, r_err, r_saw_req, r_req_at_rsp, r_ready_after;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Issues one command and plays the arbiter/slave side until rsp_valid or the cycle budget expires
    task automatic run_cmd(input bit wr, input bit [1:0] sl, input bit [11:0] ad, input bit [7:0] wd,
                           input bit [7:0] rd, input int req_stall, input int st_at, input int st_len,
                           input bit no_ret);
        int rd_idx = 0;
        int st_cnt = 0;
        bit stalling;
        r_abits = '0; r_dbits = '0; r_rdata = '0;
        r_nack = 0; r_rsp_cyc = 0; r_last_ack = 0; r_wen_bad = 0; r_stall_bad = 0;
        r_got = 0; r_err = 0; r_saw_req = 0; r_req_at_rsp = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_slave = sl; cmd_addr = ad; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 600 && !r_got; cyc++) begin
            stalling    = 1'b0;
            m_available = (cyc > req_stall);
            m_ready     = 1'b1;
            m_valid_in  = 1'b0;
            m_data_in   = 1'b0;
            if (st_at >= 0 && r_nack == st_at && st_cnt < st_len) begin
                m_available = 1'b0;
                stalling    = 1'b1;
                st_cnt++;
            end
            if (!wr && !no_ret && r_nack == 15 && rd_idx < 8 && (cyc % 2 == 1)) begin
                m_valid_in = 1'b1;
                m_data_in  = rd[7-rd_idx];
                rd_idx++;
            end
            #1;
            if (m_request) r_saw_req = 1'b1;
            if (cyc <= req_stall && !(m_request && m_address_valid)) r_stall_bad++;
            if (stalling && (!m_request || (st_cnt > 1 && m_valid))) r_stall_bad++;
            if (rsp_valid) begin
                r_got        = 1'b1;
                r_err        = rsp_error;
                r_rdata      = rsp_rdata;
                r_rsp_cyc    = cyc;
                r_req_at_rsp = m_request;
            end else if (m_valid && m_available && m_ready) begin
                if (r_nack >= 3 && r_nack < 15 && m_write_en !== wr) r_wen_bad++;
                r_abits    = {r_abits[21:0], m_address};
                r_dbits    = {r_dbits[21:0], m_data};
                r_nack++;
                r_last_ack = cyc;
            end
            @(posedge clk); #1;
        end
        r_ready_after = cmd_ready;
        m_available = 1'b0;
        m_ready     = 1'b0;
        m_valid_in  = 1'b0;
    endtask

    initial begin
        bit found;
        int rsp_seen, req_seen;

        reset = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave = '0; cmd_addr = '0; cmd_wdata = '0;
        m_available = 1'b0; m_ready = 1'b0; m_data_in = 1'b0; m_valid_in = 1'b0;

        vt[0] = '{wr: 1'b1, sl: 2'd1, ad: 12'hABC, wd: 8'h5A, rd: 8'h00,
                  ea: 23'b001_101010111100_00000000, ed: 23'b000_000000000000_01011010,
                  en: 23, ee: 1'b0, er: 8'h00};
        vt[1] = '{wr: 1'b0, sl: 2'd2, ad: 12'h123, wd: 8'h00, rd: 8'hC3,
                  ea: {8'h00, 3'b110, 12'h123}, ed: 23'h0, en: 15, ee: 1'b0, er: 8'hC3};
        vt[2] = '{wr: 1'b1, sl: 2'd0, ad: 12'hFFF, wd: 8'h81, rd: 8'h00,
                  ea: {3'b000, 12'hFFF, 8'h00}, ed: {15'h0, 8'h81}, en: 23, ee: 1'b0, er: 8'hC3};
        vt[3] = '{wr: 1'b0, sl: 2'd1, ad: 12'h800, wd: 8'h00, rd: 8'h01,
                  ea: {8'h00, 3'b001, 12'h800}, ed: 23'h0, en: 15, ee: 1'b0, er: 8'h01};
        vt[4] = '{wr: 1'b1, sl: 2'd3, ad: 12'h321, wd: 8'h77, rd: 8'h00,
                  ea: 23'h0, ed: 23'h0, en: 0, ee: 1'b1, er: 8'h01};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_outputs", {m_request, m_address_valid, m_address, m_data, m_valid, m_write_en,
                            rsp_valid, rsp_error}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_cmd(vt[i].wr, vt[i].sl, vt[i].ad, vt[i].wd, vt[i].rd, 0, -1, 0, 1'b0);
            chk($sformatf("v%0d_rsp_seen", i), r_got, 1);
            chk($sformatf("v%0d_error", i), r_err, vt[i].ee);
            chk($sformatf("v%0d_rdata", i), r_rdata, vt[i].er);
            chk($sformatf("v%0d_nbits", i), r_nack, vt[i].en);
            chk($sformatf("v%0d_addr_bits", i), r_abits, vt[i].ea);
            chk($sformatf("v%0d_data_bits", i), r_dbits, vt[i].ed);
            chk($sformatf("v%0d_write_en", i), r_wen_bad, 0);
            chk($sformatf("v%0d_requested", i), r_saw_req, vt[i].sl != 2'd3);
            chk($sformatf("v%0d_ready_after", i), r_ready_after, 1);
            if (vt[i].sl == 2'd3) chk("illegal_latency_le2", r_rsp_cyc <= 2, 1);
        end

        // Grant withheld for 20 cycles, then a normal read
        run_cmd(1'b0, 2'd0, 12'h0F0, 8'h00, 8'h5C, 20, -1, 0, 1'b0);
        chk("reqstall_hold", r_stall_bad, 0);
        chk("reqstall_rsp_seen", r_got, 1);
        chk("reqstall_error", r_err, 0);
        chk("reqstall_rdata", r_rdata, 8'h5C);
        chk("reqstall_addr_bits", r_abits, {8'h00, 3'b000, 12'h0F0});

        // Bus lost after 4 address bits for 10 cycles
        run_cmd(1'b1, 2'd2, 12'hABC, 8'h3C, 8'h00, 0, 7, 10, 1'b0);
        chk("split_susp_outputs", r_stall_bad, 0);
        chk("split_nbits", r_nack, 23);
        chk("split_addr_bits", r_abits, {3'b110, 12'hABC, 8'h00});
        chk("split_data_bits", r_dbits, {15'h0, 8'h3C});
        chk("split_rsp_cycle", r_rsp_cyc, 37);
        chk("split_error", r_err, 0);

        // Read whose data never arrives
        run_cmd(1'b0, 2'd1, 12'h456, 8'h00, 8'h00, 0, -1, 0, 1'b1);
        chk("timeout_rsp_seen", r_got, 1);
        chk("timeout_error", r_err, 1);
        chk("timeout_rdata_kept", r_rdata, 8'h5C);
        chk("timeout_latency", r_rsp_cyc - r_last_ack, 257);
        chk("timeout_req_dropped", r_req_at_rsp, 0);

        // Reset asserted in the middle of the address phase
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slave = 2'd1; cmd_addr = 12'h555; cmd_wdata = 8'hFF;
        m_available = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_valid && m_write_en) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rstmid_reached_addr", found, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_bus_zero", {m_request, m_address_valid, m_address, m_data, m_valid, m_write_en,
                                rsp_valid, rsp_error}, 0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        chk("rstmid_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rsp_seen = 0;
        req_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_seen++;
            if (m_request) req_seen++;
        end
        chk("rstmid_no_rsp", rsp_seen, 0);
        chk("rstmid_no_req", req_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
